slink_int_gpio_irq_ctrl: RTL and testbench
==========================================

# slink_int_gpio_irq_ctrl

Interrupt controller on the receive side of the S-Link interrupt/GPIO bridge. Consumes the remote interrupt vector delivered by the int/GPIO application block in the `app_clk` domain and latches each bit into a pending register using a per-bit edge or level mode. It applies a mask and drives one coalesced, hold-off-delayed `irq` to the local CPU, along with the lowest pending ID. Software acknowledges interrupts with a write-1-to-clear strobe.

## Interface
**Parameters**
- `NUM_INTS`, default 16: number of interrupt lines (multiple of 8).
- `HOLDOFF_WIDTH`, default 8: width of the coalescing hold-off counter.
- `ID_WIDTH`, localparam: `$clog2(NUM_INTS)`, minimum 1.

**Ports**
- `app_clk`, input, 1: sole clock.
- `app_reset_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: block enable, already synchronous to `app_clk`.
- `i_interrupt`, input, `NUM_INTS`: received interrupt vector, synchronous to `app_clk`.
- `swi_int_mode`, input, `NUM_INTS`: per bit, 1 = rising edge, 0 = level-high.
- `swi_int_mask`, input, `NUM_INTS`: per bit, 1 = contributes to `irq`.
- `swi_holdoff`, input, `HOLDOFF_WIDTH`: coalescing delay in cycles; 0 = none.
- `clr_valid`, input, 1: clear strobe, single cycle.
- `clr_mask`, input, `NUM_INTS`: write-1-to-clear bits, qualified by `clr_valid`.
- `pending`, output, `NUM_INTS`: registered pending bits, unmasked.
- `overflow`, output, `NUM_INTS`: sticky; an edge arrived while that bit was already pending.
- `irq`, output, 1: coalesced interrupt request.
- `irq_id`, output, `ID_WIDTH`: index of the lowest set bit of `pending & swi_int_mask`; 0 when none.

## Operation
- `prev` register holds last-cycle `i_interrupt` and always updates, including while `enable` is low.
- Event generation:
  - Edge-mode event: `mode & i & ~prev`.
  - Level-mode event: `~mode & i`.
- Clear vector `clr` = `clr_valid ? clr_mask : 0`.
- Pending update: `pending_next = (pending & ~clr) | event`. A set in the same cycle as its clear wins, so the bit stays 1.
- Overflow update: `overflow_next = (overflow & ~clr) | (event & mode & pending & ~clr)`.
- Level-mode source held high: its pending bit re-asserts every cycle, so a clear has no visible effect.
- `active = |(pending & swi_int_mask)`. Mask changes take effect on the next FSM evaluation and never alter `pending`.
- `enable` low: `pending` and `overflow` forced to 0, FSM forced to IDLE, events ignored.
  - Because `prev` keeps tracking, a line already high when `enable` rises is not an edge.
- FSM, states IDLE, HOLDOFF, ASSERT:
  - IDLE:
    - If `active` and `swi_holdoff == 0`: go to ASSERT.
    - If `active` and `swi_holdoff != 0`: load `cnt = swi_holdoff`, go to HOLDOFF.
  - HOLDOFF:
    - If `!active`: go to IDLE.
    - Else if `cnt == 1`: go to ASSERT.
    - Else: `cnt--`.
  - ASSERT: if `!active`, go to IDLE.
- `irq` = (state == ASSERT), decoded directly from the state register with no combinational input path.
- `irq_id` is a combinational priority encode of registered `pending & swi_int_mask`, lowest index wins.
- Reset values: `prev` 0, `pending` 0, `overflow` 0, `cnt` 0, state IDLE, `irq` 0, `irq_id` 0.
  - Since `prev` resets to 0, an edge-mode line high at the first post-reset cycle counts as an edge.

## Timing
- `i_interrupt` bit rises before edge k: `pending` high after edge k.
  - `swi_holdoff == 0`: `irq` high after edge k+1.
  - `swi_holdoff == H`: `irq` high after edge k+1+H.
- Clear at edge m of the last active bit: `pending` low after m, state IDLE after m+1, `irq` low after m+1.
- `swi_holdoff` is sampled only on the IDLE-to-HOLDOFF transition; changing it mid-holdoff has no effect.
- `app_reset_n` assertion mid-operation: all state clears immediately, asynchronously. Deassertion must be synchronous to `app_clk` (handled upstream).

## Test plan
- Edge mode, bit 3, `swi_holdoff=0`, mask all 1s; pulse bit 3 for 1 cycle -> `pending=0x0008`, `irq` after 2 edges, `irq_id=3`; clear `0x0008` -> `irq` 0 one cycle after `pending` drops.
- Level mode, bit 0, held high; clear bit 0 -> `pending[0]` stays 1 and `irq` stays 1; drop the line, then clear -> both go 0.
- `swi_holdoff=5`, edge on bit 7 -> `irq` rises exactly 6 edges after `pending[7]`; clear at cycle 3 of hold-off -> `irq` never asserts and FSM returns to IDLE.
- Two edges on bit 2 with no clear between them -> `overflow[2]=1`; clear `0x0004` -> `pending[2]` and `overflow[2]` both 0; clear and a new edge in the same cycle -> `pending[2]=1`, `overflow[2]=0`.
- Bits 5 and 9 pending, mask `0xFFDF` -> `irq_id=9`; mask `0x0000` -> `irq` drops after 1 cycle, `irq_id=0`, `pending` unchanged at `0x0220`.
- Line high before `enable` rises; raise `enable` -> no edge, `pending` stays 0; assert `app_reset_n` low mid-ASSERT -> `irq`, `pending`, `overflow` go 0 immediately.

Source files
------------

// File: rtl/slink_int_gpio_irq_ctrl_if.sv
// Software-facing register bus of the S-Link interrupt controller: the
// configuration and clear strobe written by the CPU side, and the status and
// interrupt request returned by the controller.
interface slink_int_gpio_irq_ctrl_if #(
  parameter int NUM_INTS      = 16,
  parameter int HOLDOFF_WIDTH = 8
);
  localparam int ID_WIDTH = (NUM_INTS > 1) ? $clog2(NUM_INTS) : 1;

  logic [NUM_INTS-1:0]      swi_int_mode;
  logic [NUM_INTS-1:0]      swi_int_mask;
  logic [HOLDOFF_WIDTH-1:0] swi_holdoff;
  logic                     clr_valid;
  logic [NUM_INTS-1:0]      clr_mask;
  logic [NUM_INTS-1:0]      pending;
  logic [NUM_INTS-1:0]      overflow;
  logic                     irq;
  logic [ID_WIDTH-1:0]      irq_id;

  // CPU / register-file side
  modport master (
    output swi_int_mode, swi_int_mask, swi_holdoff, clr_valid, clr_mask,
    input  pending, overflow, irq, irq_id
  );

  // Interrupt controller side
  modport slave (
    input  swi_int_mode, swi_int_mask, swi_holdoff, clr_valid, clr_mask,
    output pending, overflow, irq, irq_id
  );
endinterface

// File: rtl/slink_int_gpio_irq_ctrl.sv
// Receive-side interrupt controller of the S-Link interrupt/GPIO bridge.
// Latches the remote interrupt vector into a pending register (per-bit edge or
// level mode), tracks sticky overflow for edge sources, and drives a single
// masked, hold-off-coalesced irq plus the lowest pending masked ID.
module slink_int_gpio_irq_ctrl #(
  parameter int NUM_INTS      = 16,
  parameter int HOLDOFF_WIDTH = 8
) (
  input  logic                app_clk,
  input  logic                app_reset_n,
  input  logic                enable,
  input  logic [NUM_INTS-1:0] i_interrupt,
  slink_int_gpio_irq_ctrl_if.slave bus
);

  localparam int ID_WIDTH = (NUM_INTS > 1) ? $clog2(NUM_INTS) : 1;

  if ((NUM_INTS % 8) != 0 || NUM_INTS < 8) begin : g_bad_num_ints
    $error("NUM_INTS must be a non-zero multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDOFF = 2'd1,
    ASSERT  = 2'd2
  } state_t;

  logic [NUM_INTS-1:0]      prev_q;
  logic [NUM_INTS-1:0]      pending_q;
  logic [NUM_INTS-1:0]      overflow_q;
  logic [NUM_INTS-1:0]      edge_evt;
  logic [NUM_INTS-1:0]      level_evt;
  logic [NUM_INTS-1:0]      evt;
  logic [NUM_INTS-1:0]      clr;
  logic [NUM_INTS-1:0]      masked;
  logic                     active;
  logic [HOLDOFF_WIDTH-1:0] cnt_q;
  logic [HOLDOFF_WIDTH-1:0] cnt_d;
  state_t                   state_q;
  state_t                   state_d;
  logic [ID_WIDTH-1:0]      id_enc;

  // Event detection: rising edges for edge-mode bits, high level otherwise.
  assign edge_evt  = bus.swi_int_mode & i_interrupt & ~prev_q;
  assign level_evt = ~bus.swi_int_mode & i_interrupt;
  assign evt       = edge_evt | level_evt;
  assign clr       = bus.clr_valid ? bus.clr_mask : '0;
  assign masked    = pending_q & bus.swi_int_mask;
  assign active    = |masked;

  // Previous-cycle input copy; keeps tracking while disabled so that a line
  // already high when enable rises is not mistaken for an edge.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge app_clk or negedge app_reset_n) begin
    if (!app_reset_n) prev_q <= '0;
    else              prev_q <= i_interrupt;
  end

  // Pending and sticky overflow; a set in the same cycle as its clear wins.
  always_ff @(posedge app_clk or negedge app_reset_n) begin
    if (!app_reset_n) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else if (!enable) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= (pending_q & ~clr) | evt;
      overflow_q <= (overflow_q & ~clr) | (edge_evt & pending_q & ~clr);
    end
  end

  // Coalescing FSM state and hold-off counter registers.
  always_ff @(posedge app_clk or negedge app_reset_n) begin
    if (!app_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; swi_holdoff is only sampled when leaving IDLE.
  // NOTE: every output of this block is given a default before the case, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (active) begin
            if (bus.swi_holdoff == '0) begin
              state_d = ASSERT;
            end else begin
              cnt_d   = bus.swi_holdoff;
              state_d = HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (!active)                             state_d = IDLE;
          else if (cnt_q == HOLDOFF_WIDTH'(1))     state_d = ASSERT;
          else                                     cnt_d   = cnt_q - HOLDOFF_WIDTH'(1);
        end
        ASSERT: begin
          if (!active) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Lowest-index priority encode of the masked pending bits; 0 when none.
  always_comb begin
    id_enc = '0;
    for (int i = NUM_INTS - 1; i >= 0; i--) begin
      if (masked[i]) id_enc = ID_WIDTH'(i);
    end
  end

  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
  assign bus.irq      = (state_q == ASSERT);
  assign bus.irq_id   = id_enc;

endmodule

// File: tb/tb_slink_int_gpio_irq_ctrl.sv
// Directed bench for slink_int_gpio_irq_ctrl: each task drives one scenario
// and compares outputs against hand-computed values 1 ns after the edge.
module tb_slink_int_gpio_irq_ctrl;
  localparam int NUM_INTS      = 16;
  localparam int HOLDOFF_WIDTH = 8;
  localparam int ID_WIDTH      = 4;

  logic                app_clk = 1'b0;
  logic                app_reset_n;
  logic                enable;
  logic [NUM_INTS-1:0] i_interrupt;

  int checks = 0;
  int errors = 0;

  slink_int_gpio_irq_ctrl_if #(.NUM_INTS(NUM_INTS), .HOLDOFF_WIDTH(HOLDOFF_WIDTH)) bus ();

  slink_int_gpio_irq_ctrl #(.NUM_INTS(NUM_INTS), .HOLDOFF_WIDTH(HOLDOFF_WIDTH)) dut (
    .app_clk     (app_clk),
    .app_reset_n (app_reset_n),
    .enable      (enable),
    .i_interrupt (i_interrupt),
    .bus         (bus)
  );

  always #5 app_clk = ~app_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge app_clk);
    #1;
  endtask

  task automatic clear(input logic [NUM_INTS-1:0] m);
    bus.clr_valid = 1'b1;
    bus.clr_mask  = m;
    step(1);
    bus.clr_valid = 1'b0;
    bus.clr_mask  = '0;
  endtask

  task automatic test_reset;
    app_reset_n      = 1'b0;
    enable           = 1'b0;
    i_interrupt      = '0;
    bus.swi_int_mode = '1;
    bus.swi_int_mask = '1;
    bus.swi_holdoff  = '0;
    bus.clr_valid    = 1'b0;
    bus.clr_mask     = '0;
    step(3);
    checks++; if (bus.pending !== 16'h0000) begin errors++; $display("FAIL reset_pending got %h want 0000", bus.pending); end
    checks++; if (bus.overflow !== 16'h0000) begin errors++; $display("FAIL reset_overflow got %h want 0000", bus.overflow); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", bus.irq); end
    checks++; if (bus.irq_id !== 4'd0) begin errors++; $display("FAIL reset_irq_id got %0d want 0", bus.irq_id); end
    app_reset_n = 1'b1;
    enable      = 1'b1;
    step(1);
  endtask

  task automatic test_edge;
    i_interrupt = 16'h0008;
    step(1);
    i_interrupt = '0;
    checks++; if (bus.pending !== 16'h0008) begin errors++; $display("FAIL edge_pending got %h want 0008", bus.pending); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early got %b want 0", bus.irq); end
    step(1);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL edge_irq got %b want 1", bus.irq); end
    checks++; if (bus.irq_id !== 4'd3) begin errors++; $display("FAIL edge_irq_id got %0d want 3", bus.irq_id); end
    clear(16'h0008);
    checks++; if (bus.pending !== 16'h0000) begin errors++; $display("FAIL edge_clr_pending got %h want 0000", bus.pending); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL edge_clr_irq_hold got %b want 1", bus.irq); end
    step(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL edge_clr_irq got %b want 0", bus.irq); end
  endtask

  task automatic test_level;
    bus.swi_int_mode = 16'hFFFE;
    i_interrupt      = 16'h0001;
    step(2);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL level_irq got %b want 1", bus.irq); end
    clear(16'h0001);
    checks++; if (bus.pending !== 16'h0001) begin errors++; $display("FAIL level_clr_held got %h want 0001", bus.pending); end
    step(1);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL level_irq_held got %b want 1", bus.irq); end
    i_interrupt = '0;
    step(1);
    clear(16'h0001);
    checks++; if (bus.pending !== 16'h0000) begin errors++; $display("FAIL level_clr_pending got %h want 0000", bus.pending); end
    step(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL level_clr_irq got %b want 0", bus.irq); end
    bus.swi_int_mode = '1;
  endtask

  task automatic test_holdoff;
    bus.swi_holdoff = 8'd5;
    i_interrupt     = 16'h0080;
    step(1);
    i_interrupt = '0;
    checks++; if (bus.pending !== 16'h0080) begin errors++; $display("FAIL hold_pending got %h want 0080", bus.pending); end
    for (int c = 1; c <= 6; c++) begin
      step(1);
      checks++;
      if (bus.irq !== (c == 6)) begin errors++; $display("FAIL hold_irq_edge%0d got %b want %b", c, bus.irq, (c == 6)); end
    end
    clear(16'h0080);
    step(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL hold_clr_irq got %b want 0", bus.irq); end

    // Clear during hold-off: irq must never rise.
    i_interrupt = 16'h0080;
    step(1);
    i_interrupt = '0;
    step(3);
    clear(16'h0080);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL hold_abort_irq cycle%0d got %b want 0", c, bus.irq); end
      step(1);
    end

    // Hold-off value is latched on entry; a later change does not stretch it.
    bus.swi_holdoff = 8'd3;
    i_interrupt     = 16'h0080;
    step(1);
    i_interrupt = '0;
    step(1);
    bus.swi_holdoff = 8'd10;
    step(2);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL hold_latch_early got %b want 0", bus.irq); end
    step(1);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL hold_latch_irq got %b want 1", bus.irq); end
    bus.swi_holdoff = 8'd0;
    clear(16'h0080);
    step(1);
  endtask

  task automatic test_overflow;
    i_interrupt = 16'h0004; step(1);
    i_interrupt = '0;       step(1);
    i_interrupt = 16'h0004; step(1);
    i_interrupt = '0;
    checks++; if (bus.overflow !== 16'h0004) begin errors++; $display("FAIL ovf_set got %h want 0004", bus.overflow); end
    clear(16'h0004);
    checks++; if (bus.pending !== 16'h0000) begin errors++; $display("FAIL ovf_clr_pending got %h want 0000", bus.pending); end
    checks++; if (bus.overflow !== 16'h0000) begin errors++; $display("FAIL ovf_clr got %h want 0000", bus.overflow); end
    i_interrupt = 16'h0004; step(1);
    i_interrupt = '0;       step(1);
    // Edge and clear together while already pending: set wins, no overflow.
    i_interrupt   = 16'h0004;
    bus.clr_valid = 1'b1;
    bus.clr_mask  = 16'h0004;
    step(1);
    bus.clr_valid = 1'b0;
    bus.clr_mask  = '0;
    i_interrupt   = '0;
    checks++; if (bus.pending !== 16'h0004) begin errors++; $display("FAIL ovf_same_pending got %h want 0004", bus.pending); end
    checks++; if (bus.overflow !== 16'h0000) begin errors++; $display("FAIL ovf_same_overflow got %h want 0000", bus.overflow); end
    clear(16'h0004);
    step(2);
  endtask

  task automatic test_irq_id;
    i_interrupt = 16'h0220;
    step(1);
    i_interrupt = '0;
    checks++; if (bus.pending !== 16'h0220) begin errors++; $display("FAIL id_pending got %h want 0220", bus.pending); end
    step(1);
    checks++; if (bus.irq_id !== 4'd5) begin errors++; $display("FAIL id_lowest got %0d want 5", bus.irq_id); end
    bus.swi_int_mask = 16'hFFDF;
    #1;
    checks++; if (bus.irq_id !== 4'd9) begin errors++; $display("FAIL id_masked got %0d want 9", bus.irq_id); end
    bus.swi_int_mask = 16'h0000;
    #1;
    checks++; if (bus.irq_id !== 4'd0) begin errors++; $display("FAIL id_none got %0d want 0", bus.irq_id); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL id_irq_before got %b want 1", bus.irq); end
    step(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL id_irq_mask0 got %b want 0", bus.irq); end
    checks++; if (bus.pending !== 16'h0220) begin errors++; $display("FAIL id_pending_kept got %h want 0220", bus.pending); end
    bus.swi_int_mask = '1;
    clear(16'h0220);
    step(2);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL id_cleanup_irq got %b want 0", bus.irq); end
  endtask

  task automatic test_enable;
    enable = 1'b0;
    i_interrupt = 16'h0010;
    step(2);
    checks++; if (bus.pending !== 16'h0000) begin errors++; $display("FAIL en_off_pending got %h want 0000", bus.pending); end
    enable = 1'b1;
    step(1);
    checks++; if (bus.pending !== 16'h0000) begin errors++; $display("FAIL en_no_edge got %h want 0000", bus.pending); end
    step(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL en_no_irq got %b want 0", bus.irq); end
    i_interrupt = 16'h0012; step(1);
    checks++; if (bus.pending !== 16'h0002) begin errors++; $display("FAIL en_pending got %h want 0002", bus.pending); end
    i_interrupt = 16'h0010; step(1);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL en_irq got %b want 1", bus.irq); end
    i_interrupt = 16'h0012; step(1);
    checks++; if (bus.overflow !== 16'h0002) begin errors++; $display("FAIL en_overflow got %h want 0002", bus.overflow); end
    // Asynchronous reset mid-ASSERT, checked before any clock edge.
    app_reset_n = 1'b0;
    #2;
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL arst_irq got %b want 0", bus.irq); end
    checks++; if (bus.pending !== 16'h0000) begin errors++; $display("FAIL arst_pending got %h want 0000", bus.pending); end
    checks++; if (bus.overflow !== 16'h0000) begin errors++; $display("FAIL arst_overflow got %h want 0000", bus.overflow); end
    i_interrupt = '0;
    step(1);
    app_reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_holdoff();
    test_overflow();
    test_irq_id();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
